// File: rtl/fsm_trace_monitor.sv
// Trace monitor for the 6-state control FSM: classifies each sampled {m,n,t},
// keeps saturating per-class counters and flags illegal codes, long t-runs and S9/S6 ping-pong.
module fsm_trace_monitor #(
    parameter int CNT_W   = 8,
    parameter int RUN_MAX = 4,
    parameter int OSC_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             clr,
    input  logic             m,
    input  logic             n,
    input  logic             t,
    input  logic [2:0]       sel,
    output logic [CNT_W-1:0] cnt_out,
    output logic [2:0]       cls,
    output logic             alarm,
    output logic             osc,
    output logic             err
);

    typedef enum logic [1:0] {MON_IDLE, MON_RUN, MON_ALARM, MON_ERR} mon_state_e;

    localparam logic [2:0]       CLS_ILL = 3'd7;
    localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_MAX);
    localparam logic [CNT_W-1:0] OSC_LIM = CNT_W'(OSC_MAX);

    mon_state_e       r_state;
    logic [CNT_W-1:0] r_cnt [5];
    logic [CNT_W-1:0] r_cnt_ill;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_alt;
    logic [2:0]       r_cls;
    logic             r_alarm;
    logic             r_osc;
    logic             r_err;

    logic [2:0]       w_cls;
    logic             w_ill;
    logic             w_is_alt;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_alt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // NOTE: default assignment first so every path drives w_cls and no latch is inferred.
        w_cls = CLS_ILL;
        case ({m, n, t})
            3'b100:  w_cls = 3'd0;
            3'b000:  w_cls = 3'd1;
            3'b001:  w_cls = 3'd2;
            3'b110:  w_cls = 3'd3;
            3'b010:  w_cls = 3'd4;
            default: w_cls = CLS_ILL;
        endcase
    end

    // In MON_IDLE there is no previous class, so the first sample never counts as an alternation.
    assign w_ill     = (w_cls == CLS_ILL);
    assign w_is_alt  = (r_state != MON_IDLE) &&
                       (((w_cls == 3'd3) && (r_cls == 3'd4)) || ((w_cls == 3'd4) && (r_cls == 3'd3)));
    assign w_run_nxt = t ? sat_inc(r_run) : '0;
    assign w_alt_nxt = w_is_alt ? sat_inc(r_alt) : '0;

    always_ff @(posedge clk) begin
        if (rst_b || clr) begin
            // NOTE: the counter array is read back through cnt_out, so every entry is cleared explicitly.
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
            r_cnt_ill <= '0;
            r_total   <= '0;
            r_run     <= '0;
            r_alt     <= '0;
            r_cls     <= '0;
            r_osc     <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of its peers.
            for (int i = 0; i < 5; i++) begin
                if (w_cls == 3'(i)) r_cnt[i] <= sat_inc(r_cnt[i]);
            end
            if (w_ill) r_cnt_ill <= sat_inc(r_cnt_ill);
            r_total <= sat_inc(r_total);
            r_run   <= w_run_nxt;
            r_alt   <= w_alt_nxt;
            r_cls   <= w_cls;
            r_osc   <= (w_alt_nxt >= OSC_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b || clr) begin
            r_state <= MON_IDLE;
            r_alarm <= 1'b0;
            r_err   <= 1'b0;
        end else if (en) begin
            case (r_state)
                MON_IDLE, MON_RUN: begin
                    if (w_ill) begin
                        r_state <= MON_ERR;
                        r_alarm <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_run_nxt >= RUN_LIM) begin
                        r_state <= MON_ALARM;
                        r_alarm <= 1'b1;
                    end else begin
                        r_state <= MON_RUN;
                        r_alarm <= 1'b0;
                    end
                end
                MON_ALARM: begin
                    if (w_ill) begin
                        r_state <= MON_ERR;
                        r_alarm <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (!t) begin
                        r_state <= MON_RUN;
                        r_alarm <= 1'b0;
                    end
                end
                MON_ERR: begin
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_out = '0;
        case (sel)
            3'd0:    cnt_out = r_cnt[0];
            3'd1:    cnt_out = r_cnt[1];
            3'd2:    cnt_out = r_cnt[2];
            3'd3:    cnt_out = r_cnt[3];
            3'd4:    cnt_out = r_cnt[4];
            3'd5:    cnt_out = r_cnt_ill;
            3'd6:    cnt_out = r_total;
            default: cnt_out = r_run;
        endcase
    end

    assign cls   = r_cls;
    assign alarm = r_alarm;
    assign osc   = r_osc;
    assign err   = r_err;

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// Bench for fsm_trace_monitor: a default-width and a 3-bit-counter instance share stimulus and are
// compared against an unbounded-count reference model that is clamped only when read.
module tb_fsm_trace_monitor;

    localparam int RUN_MAX = 4;
    localparam int OSC_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_b, en, clr, m, n, t;
    logic [2:0] sel;

    logic [7:0] cnt_out_a;
    logic [2:0] cls_a;
    logic       alarm_a, osc_a, err_a;
    logic [2:0] cnt_out_b;
    logic [2:0] cls_b;
    logic       alarm_b, osc_b, err_b;

    always #10 clk = ~clk;

    fsm_trace_monitor #(.CNT_W(8), .RUN_MAX(RUN_MAX), .OSC_MAX(OSC_MAX)) u_dut (
        .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .m(m), .n(n), .t(t), .sel(sel),
        .cnt_out(cnt_out_a), .cls(cls_a), .alarm(alarm_a), .osc(osc_a), .err(err_a)
    );

    fsm_trace_monitor #(.CNT_W(3), .RUN_MAX(RUN_MAX), .OSC_MAX(OSC_MAX)) u_dut_w3 (
        .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .m(m), .n(n), .t(t), .sel(sel),
        .cnt_out(cnt_out_b), .cls(cls_b), .alarm(alarm_b), .osc(osc_b), .err(err_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain unbounded counts since the last reset/clear.
    int m_cnt [5];
    int m_ill, m_total, m_run, m_alt, m_cls;
    bit m_have_prev, m_err;

    function automatic int classify(input logic [2:0] c);
        case (c)
            3'b100:  return 0;
            3'b000:  return 1;
            3'b001:  return 2;
            3'b110:  return 3;
            3'b010:  return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_ill = 0; m_total = 0; m_run = 0; m_alt = 0; m_cls = 0;
        m_have_prev = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_sample(input logic [2:0] c);
        int k;
        k = classify(c);
        if (k == 7) begin
            m_ill++;
            m_err = 1'b1;
        end else begin
            m_cnt[k]++;
        end
        m_total++;
        m_run = c[0] ? m_run + 1 : 0;
        if (m_have_prev && ((k == 3 && m_cls == 4) || (k == 4 && m_cls == 3))) m_alt++;
        else m_alt = 0;
        m_cls = k;
        m_have_prev = 1'b1;
    endtask

    function automatic int exp_cnt(input int s, input int w);
        if (s < 5) return sat(m_cnt[s], w);
        if (s == 5) return sat(m_ill, w);
        if (s == 6) return sat(m_total, w);
        return sat(m_run, w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        logic [31:0] e_alarm;
        e_alarm = (!m_err && m_run >= RUN_MAX) ? 1 : 0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("%s cnt_out_a[sel=%0d]", step, s), {24'b0, cnt_out_a}, exp_cnt(s, 8));
            check($sformatf("%s cnt_out_b[sel=%0d]", step, s), {29'b0, cnt_out_b}, exp_cnt(s, 3));
        end
        check({step, " cls_a"},   {29'b0, cls_a},   m_cls);
        check({step, " cls_b"},   {29'b0, cls_b},   m_cls);
        check({step, " alarm_a"}, {31'b0, alarm_a}, e_alarm);
        check({step, " alarm_b"}, {31'b0, alarm_b}, e_alarm);
        check({step, " osc_a"},   {31'b0, osc_a},   (m_alt >= OSC_MAX) ? 1 : 0);
        check({step, " osc_b"},   {31'b0, osc_b},   (m_alt >= OSC_MAX) ? 1 : 0);
        check({step, " err_a"},   {31'b0, err_a},   m_err);
        check({step, " err_b"},   {31'b0, err_b},   m_err);
    endtask

    task automatic apply(input logic e, input logic c, input logic [2:0] code);
        en = e; clr = c; {m, n, t} = code;
        @(posedge clk);
        if (c) model_clear();
        else if (e) model_sample(code);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_b = 1'b1;
        repeat (cycles) @(posedge clk);
        model_clear();
        #1;
        rst_b = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] code;
        int         r;

        rst_b = 1'b1; en = 1'b0; clr = 1'b0; {m, n, t} = 3'b000; sel = 3'd0;
        do_reset(2);
        check_all("reset");

        // Full legal trace S0,S9,S6,S5,S3,S2.
        apply(1, 0, 3'b100); apply(1, 0, 3'b010); apply(1, 0, 3'b110);
        apply(1, 0, 3'b001); apply(1, 0, 3'b001); apply(1, 0, 3'b000);
        check_all("trace");

        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 3'b001);
            check_all($sformatf("t_run%0d", i + 1));
        end
        apply(1, 0, 3'b000);
        check_all("t_run_end");

        apply(1, 0, 3'b010); apply(1, 0, 3'b110); apply(1, 0, 3'b010);
        check_all("osc_3");
        apply(1, 0, 3'b110);
        check_all("osc_4");
        apply(1, 0, 3'b001);
        check_all("osc_break");

        apply(1, 0, 3'b000);
        apply(1, 0, 3'b111);
        check_all("illegal");
        apply(1, 0, 3'b100); apply(1, 0, 3'b001); apply(1, 0, 3'b001);
        apply(1, 0, 3'b001); apply(1, 0, 3'b001);
        check_all("err_sticky");
        apply(1, 1, 3'b100);
        check_all("clr_drops_sample");

        for (int i = 0; i < 9; i++) apply(1, 0, 3'b000);
        check_all("saturate");

        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 3'(i + 1));
            check_all($sformatf("hold%0d", i));
        end

        apply(1, 0, 3'b010);
        rst_b = 1'b1;
        apply(1, 0, 3'b001);
        rst_b = 1'b0;
        model_clear();
        check_all("reset_mid");
        apply(1, 0, 3'b110);
        check_all("first_after_reset");

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25)      code = 3'b001;
            else if (r < 45) code = 3'b010;
            else if (r < 65) code = 3'b110;
            else if (r < 78) code = 3'b000;
            else if (r < 97) code = 3'b100;
            else if (r < 98) code = 3'b011;
            else if (r < 99) code = 3'b101;
            else             code = 3'b111;
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                apply(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0), code);
            end
            check_all($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_trace_monitor.md
Name: fsm_trace_monitor

Overview:
- Downstream consumer of the 6-state control FSM's Moore outputs m, n, t.
- Samples the output triple each enabled cycle and classifies it into a state class.
- Keeps saturating per-class occurrence counters.
- Flags illegal codes, over-long runs of t, and S9/S6 ping-pong oscillation.
- Used as an on-chip checker and debug-readout stage behind the FSM.

Parameters:
- CNT_W, 8: width of every counter and of cnt_out.
- RUN_MAX, 4: t-run length at which alarm asserts.
- OSC_MAX, 3: number of consecutive class-4/class-3 alternations at which osc asserts.

Ports:
- clk  input  1  rising-edge clock.
- rst_b  input  1  synchronous active-high reset; 1 = reset.
- en  input  1  sample strobe; m/n/t are consumed only when en=1.
- clr  input  1  synchronous clear of counters, flags and monitor FSM.
- m  input  1  FSM output m.
- n  input  1  FSM output n.
- t  input  1  FSM output t.
- sel  input  3  readout select for cnt_out.
- cnt_out  output  CNT_W  selected counter value.
- cls  output  3  class of last accepted sample.
- alarm  output  1  t-run alarm.
- osc  output  1  oscillation flag.
- err  output  1  sticky illegal-code flag.

Behaviour:
- Classification of {m,n,t}:
  - 100 -> cls 0 (S0).
  - 000 -> cls 1 (S2).
  - 001 -> cls 2 (S3/S5).
  - 110 -> cls 3 (S6).
  - 010 -> cls 4 (S9).
  - any other code -> cls 7 (illegal).
- Priority, evaluated at each rising edge: rst_b > clr > en sample. When clr=1 and en=1 in the same cycle, the sample is discarded.
- Reset or clr:
  - all counters = 0, run = 0, alt = 0.
  - cls = 0, alarm = 0, osc = 0, err = 0.
  - monitor FSM = MON_IDLE.
- Latency: cls, flags and counters update on the edge where en=1; they are visible in the next cycle.
- Holding: with en=0, every register holds its value.
- Counters (all saturate at 2^CNT_W-1 and never wrap):
  - cnt[0..4]: per-class counts.
  - cnt_ill: illegal-code count.
  - total: accepted samples.
  - run: consecutive accepted samples with t=1; reset to 0 on any accepted sample with t=0.
- cnt_out is combinational from registers, zero latency from sel:
  - sel 0-4 -> cnt[sel].
  - sel 5 -> cnt_ill.
  - sel 6 -> total.
  - sel 7 -> run.
- Oscillation tracker:
  - alt increments (saturating) when the accepted cls is 3 and the previous cls was 4, or vice versa.
  - Any other accepted class sets alt = 0.
  - osc = (alt >= OSC_MAX), registered.
- Monitor FSM states: MON_IDLE, MON_RUN, MON_ALARM, MON_ERR.
  - MON_IDLE: first accepted sample -> MON_RUN, or -> MON_ERR if illegal. The previous cls is treated as "none", so no alternation is counted.
  - MON_RUN: illegal -> MON_ERR. Sample making run reach RUN_MAX -> MON_ALARM.
  - MON_ALARM: alarm = 1. Accepted sample with t=0 -> MON_RUN with alarm = 0. Illegal -> MON_ERR.
  - MON_ERR: err = 1; alarm is forced to 0. Counting continues. Exit only by clr or reset.
- alarm is registered and asserts in the cycle after the RUN_MAX-th consecutive t=1 sample.
- Reset mid-run: all state is lost; the next sample is treated as the first.

Test Plan:
- Reset with rst_b=1 for 2 cycles, sel swept 0-7 -> cnt_out=0 for every sel; cls=0; alarm=osc=err=0.
- Trace S0,S9,S6,S5,S3,S2 as {m,n,t}=100,010,110,001,001,000 with en=1 -> cnt[0]=1, cnt[1]=1, cnt[2]=2, cnt[3]=1, cnt[4]=1; total=6; alarm=0 (run peaked at 2).
- Five consecutive 001 samples with RUN_MAX=4 -> alarm=1 the cycle after the 4th sample, still 1 after the 5th, run=5; then one 000 sample -> alarm=0, run=0.
- Alternate 010,110,010,110 with OSC_MAX=3 -> osc=1 after the 4th sample (alt=3); then a 001 sample -> osc=0.
- Inject 111 mid-trace -> err=1, cls=7, cnt_ill=1; further valid samples keep err=1 and are still counted; clr=1 -> all counters and flags 0.
- Saturation and priority:
  - CNT_W=3, nine 000 samples -> cnt[1]=7.
  - clr=1 together with en=1 and 100 -> the sample is dropped, all counters 0.
  - en=0 with a changing m/n/t -> no register changes.
